// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver, optional even parity, 1 stop bit, mid-bit sampling
// Optional error counter port err_cnt enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 8000000,
    parameter int BAUD_RATE   = 38400,
    parameter int PARITY_EN   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_en,
    output logic [7:0] data,
    output logic       word_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int DIV   = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     state_q, state_d;
    logic       sync1_q, rxs_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_bit_q, par_bit_d;
    logic [7:0] data_q, data_d;
    logic       word_done_q, word_done_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    // Set after a frame ends on a low stop bit (break); blocks re-arming until the line goes high.
    logic       wait_high_q, wait_high_d;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
`endif

    logic cnt_full;
    logic cnt_half;

    assign cnt_full = (cnt_q == CNT_W'(DIV - 1));
    assign cnt_half = (cnt_q == CNT_W'(HALF - 1));

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    // Next-state, bit timing and frame result computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        data_d       = data_q;
        word_done_d  = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        wait_high_d  = wait_high_q;
`ifdef UART_RX_ERR_CNT_EN
        err_cnt_d    = err_cnt_q;
`endif
        if (state_q != S_IDLE && !rx_en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (wait_high_q) begin
                        if (rxs_q) begin
                            wait_high_d = 1'b0;
                        end
                    end else if (rx_en && !rxs_q) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (cnt_half) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_full) begin
                        cnt_d     = '0;
                        shift_d   = {rxs_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_full) begin
                        cnt_d     = '0;
                        par_bit_d = rxs_q;
                        state_d   = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_full) begin
                        cnt_d        = '0;
                        data_d       = shift_q;
                        parity_err_d = (PARITY_EN != 0) ? (^shift_q ^ par_bit_q) : 1'b0;
                        frame_err_d  = ~rxs_q;
                        wait_high_d  = ~rxs_q;
                        word_done_d  = 1'b1;
                        state_d      = S_IDLE;
`ifdef UART_RX_ERR_CNT_EN
                        if ((frame_err_d || parity_err_d) && err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            data_q       <= '0;
            word_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            wait_high_q  <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            data_q       <= data_d;
            word_done_q  <= word_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            wait_high_q  <= wait_high_d;
`ifdef UART_RX_ERR_CNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign data       = data_q;
    assign word_done  = word_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_ERR_CNT_EN
    assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (no-parity and even-parity instances)
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DIV = 208;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a, rx_b, rx_en;
    logic [7:0] data_a, data_b;
    logic       wd_a, wd_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_a, err_cnt_b;
`endif

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;
    longint start_cyc   = 0;
    bit     lat_chk     = 1'b0;
    exp_t   q_a[$];
    exp_t   q_b[$];
    exp_t   ea, eb;

    uart_rx #(.CLK_FREQ_HZ(8000000), .BAUD_RATE(38400), .PARITY_EN(0)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .rx_en(rx_en),
        .data(data_a), .word_done(wd_a), .parity_err(perr_a),
        .frame_err(ferr_a), .busy(busy_a)
`ifdef UART_RX_ERR_CNT_EN
        , .err_cnt(err_cnt_a)
`endif
    );

    uart_rx #(.CLK_FREQ_HZ(8000000), .BAUD_RATE(38400), .PARITY_EN(1)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .rx_en(rx_en),
        .data(data_b), .word_done(wd_b), .parity_err(perr_b),
        .frame_err(ferr_b), .busy(busy_b)
`ifdef UART_RX_ERR_CNT_EN
        , .err_cnt(err_cnt_b)
`endif
    );

    always #62.5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && wd_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_word_done", 32'd1, 32'd0);
            end else begin
                ea = q_a.pop_front();
                check("a_data", 32'(data_a), 32'(ea.d));
                check("a_parity_err", 32'(perr_a), 32'(ea.p));
                check("a_frame_err", 32'(ferr_a), 32'(ea.f));
                if (lat_chk) begin
                    lat_chk = 1'b0;
                    check("a_latency_in_window",
                          32'((cyc - start_cyc) >= 1970 && (cyc - start_cyc) <= 1990), 32'd1);
                end
            end
        end
        if (reset === 1'b0 && wd_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_word_done", 32'd1, 32'd0);
            end else begin
                eb = q_b.pop_front();
                check("b_data", 32'(data_b), 32'(eb.d));
                check("b_parity_err", 32'(perr_b), 32'(eb.p));
                check("b_frame_err", 32'(ferr_b), 32'(eb.f));
            end
        end
    end

    task automatic set_rx(input bit inst_b, input logic v);
        if (inst_b) rx_b = v;
        else        rx_a = v;
    endtask

    // Called at a negedge; holds the bit exactly one bit period and returns at a negedge.
    task automatic drive_bit(input bit inst_b, input logic v);
        set_rx(inst_b, v);
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send(input bit inst_b, input logic [7:0] d, input logic pbit,
                        input logic stop, input bit expect_it);
        exp_t e;
        e.d = d;
        e.p = inst_b ? (^d ^ pbit) : 1'b0;
        e.f = ~stop;
        if (expect_it) begin
            if (inst_b) q_b.push_back(e);
            else        q_a.push_back(e);
        end
        set_rx(inst_b, 1'b0);
        start_cyc = cyc;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(inst_b, d[i]);
        if (inst_b) drive_bit(inst_b, pbit);
        drive_bit(inst_b, stop);
    endtask

    initial begin
        exp_t brk;
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rx_en = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_word_done", 32'(wd_a), 32'd0);
        check("rst_parity_err", 32'(perr_a), 32'd0);
        check("rst_frame_err", 32'(ferr_a), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt_a), 32'd0);
`endif
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Reset asserted while in DATA.
        rx_a = 1'b0;
        repeat (DIV * 3) @(negedge clk);
        check("midframe_busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", 32'(busy_a), 32'd0);
        check("midreset_data", 32'(data_a), 32'd0);
        check("midreset_word_done", 32'(wd_a), 32'd0);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send(1'b0, 8'h55, 1'b0, 1'b1, 1'b1);
        repeat (DIV) @(negedge clk);

        // Single 0x38 frame with latency window, then two back-to-back.
        lat_chk = 1'b1;
        send(1'b0, 8'h38, 1'b0, 1'b1, 1'b1);
        repeat (DIV) @(negedge clk);
        check("latency_checked", 32'(lat_chk), 32'd0);
        send(1'b0, 8'h38, 1'b0, 1'b1, 1'b1);
        send(1'b0, 8'h38, 1'b0, 1'b1, 1'b1);
        repeat (DIV) @(negedge clk);

        // Low stop bit.
        send(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        rx_a = 1'b1;
        repeat (DIV) @(negedge clk);
`ifdef UART_RX_ERR_CNT_EN
        check("err_cnt_after_ferr", 32'(err_cnt_a), 32'd1);
`endif

        // Break: line held low well past the frame; no new frame until it goes high.
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (DIV * 15) @(negedge clk);
        check("break_busy", 32'(busy_a), 32'd0);
        rx_a = 1'b1;
        repeat (DIV * 2) @(negedge clk);
`ifdef UART_RX_ERR_CNT_EN
        check("err_cnt_after_break", 32'(err_cnt_a), 32'd2);
`endif

        // Short glitch shorter than half a bit.
        rx_a = 1'b0;
        repeat (50) @(negedge clk);
        rx_a = 1'b1;
        repeat (DIV) @(negedge clk);
        check("glitch_busy", 32'(busy_a), 32'd0);

        // Receiver disabled for a whole frame.
        rx_en = 1'b0;
        send(1'b0, 8'h38, 1'b0, 1'b1, 1'b0);
        check("disabled_busy", 32'(busy_a), 32'd0);
        rx_en = 1'b1;
        repeat (DIV) @(negedge clk);

        // rx_en dropped mid-frame: abort, outputs keep the break frame result.
        rx_a = 1'b0;
        repeat (DIV * 2) @(negedge clk);
        check("abort_busy_before", 32'(busy_a), 32'd1);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_after", 32'(busy_a), 32'd0);
        rx_a = 1'b1;
        repeat (DIV * 10) @(negedge clk);
        check("abort_data_held", 32'(data_a), 32'd0);
        check("abort_ferr_held", 32'(ferr_a), 32'd1);
        rx_en = 1'b1;
        repeat (DIV) @(negedge clk);
        send(1'b0, 8'hC3, 1'b0, 1'b1, 1'b1);
        repeat (DIV) @(negedge clk);

        // Even-parity instance.
        send(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        send(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
        repeat (DIV) @(negedge clk);

        for (int i = 0; i < 5000 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
